sar_adc_ctrl: RTL and testbench

Successive-approximation controller that turns the on-chip R2R DAC into an analog-to-digital converter. It drives the DAC code and reads an external comparator, where comparator high means Vin ≥ Vdac. It performs a binary search MSB-first and returns a WIDTH-bit result with a one-cycle done pulse. It sits between the project's digital I/O (start, result) and the R2R ladder inputs.

---
 rtl/sar_pkg.sv | 19 +
 rtl/cmp_sync.sv | 30 +++
 rtl/sar_adc_ctrl.sv | 148 ++++++++++++++
 tb/tb_sar_adc_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared types and sizing helpers for the SAR ADC controller.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2
  } sar_state_e;

  // Bits needed to hold values 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cmp_sync.sv
// Two-flop synchronizer for the asynchronous comparator output.
// Ports: clk, rst (sync, active-high), async_i (raw input), sync_o (synchronized).
module cmp_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller driving an R2R DAC and reading an
// external comparator (1 means Vin >= Vdac). MSB-first binary search.
// Ports: clk, rst (sync, active-high), start (request, sampled in IDLE),
//        cmp (async comparator), dac_code (ladder bits), track (sample/hold),
//        busy, done (one-cycle pulse), result (last completed conversion).
module sar_adc_ctrl
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SAMPLE_CYCLES = 2,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp,
  output logic [WIDTH-1:0] dac_code,
  output logic             track,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CNT_W = cnt_width(max_u(SAMPLE_CYCLES, SETTLE_CYCLES));
  localparam int unsigned BIT_W = cnt_width(WIDTH);

  if (SAMPLE_CYCLES < 1) begin : g_bad_sample
    $error("SAMPLE_CYCLES must be >= 1");
  end
  if (SETTLE_CYCLES < 3) begin : g_bad_settle
    $error("SETTLE_CYCLES must be >= 3 to cover DAC settling and the synchronizer");
  end

  sar_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] dac_code_q, dac_code_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             track_q, track_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cmp_s;
  logic [WIDTH-1:0] decided;

  cmp_sync u_cmp_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (cmp),
    .sync_o  (cmp_s)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    dac_code_d = dac_code_q;
    result_d   = result_q;
    track_d    = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;

    // Current trial with bit i kept or cleared by the synchronized comparator.
    decided        = dac_code_q;
    decided[bit_q] = cmp_s;

    unique case (state_q)
      IDLE: begin
        dac_code_d = result_q;
        busy_d     = 1'b0;
        if (start) begin
          state_d    = SAMPLE;
          cnt_d      = CNT_W'(SAMPLE_CYCLES - 1);
          track_d    = 1'b1;
          busy_d     = 1'b1;
          dac_code_d = '0;
        end
      end

      SAMPLE: begin
        busy_d  = 1'b1;
        track_d = 1'b1;
        if (cnt_q == '0) begin
          state_d    = CONVERT;
          track_d    = 1'b0;
          bit_d      = BIT_W'(WIDTH - 1);
          cnt_d      = CNT_W'(SETTLE_CYCLES - 1);
          dac_code_d = WIDTH'(1) << (WIDTH - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      CONVERT: begin
        busy_d = 1'b1;
        if (cnt_q == '0) begin
          if (bit_q == '0) begin
            state_d    = IDLE;
            result_d   = decided;
            dac_code_d = decided;
            done_d     = 1'b1;
            busy_d     = 1'b0;
          end else begin
            bit_d      = bit_q - BIT_W'(1);
            cnt_d      = CNT_W'(SETTLE_CYCLES - 1);
            dac_code_d = decided | (WIDTH'(1) << (bit_q - BIT_W'(1)));
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      dac_code_q <= '0;
      result_q   <= '0;
      track_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      dac_code_q <= dac_code_d;
      result_q   <= result_d;
      track_q    <= track_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign dac_code = dac_code_q;
  assign track    = track_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Self-checking bench for sar_adc_ctrl: an 8-bit default instance and a
// 4-bit / SETTLE_CYCLES=3 instance, each with an ideal comparator model.
module tb_sar_adc_ctrl;
  import sar_pkg::*;

  localparam int unsigned S     = 2;
  localparam int unsigned LAT8  = S + 8 * 4;
  localparam int unsigned LAT4  = S + 4 * 3;
  localparam int unsigned CYC_W = cnt_width(LAT8 + 64);

  logic       clk = 1'b0;
  logic       rst;
  logic       start_drv;
  logic       sel4;
  logic [7:0] vin8;
  logic [3:0] vin4;

  logic       start8, cmp8, track8, busy8, done8;
  logic [7:0] dac8, res8;
  logic       start4, cmp4, track4, busy4, done4;
  logic [3:0] dac4, res4;

  logic [7:0] mon_dac, mon_res;
  logic       mon_busy, mon_track, mon_done;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int got_q[$];
  logic [CYC_W-1:0] cyc_cnt;

  always #5 clk = ~clk;

  assign start8 = start_drv && !sel4;
  assign start4 = start_drv && sel4;
  assign cmp8   = (vin8 >= dac8);
  assign cmp4   = (vin4 >= dac4);

  assign mon_dac   = sel4 ? {4'h0, dac4} : dac8;
  assign mon_res   = sel4 ? {4'h0, res4} : res8;
  assign mon_busy  = sel4 ? busy4  : busy8;
  assign mon_track = sel4 ? track4 : track8;
  assign mon_done  = sel4 ? done4  : done8;

  sar_adc_ctrl #(.WIDTH(8), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(4)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .cmp(cmp8), .dac_code(dac8),
    .track(track8), .busy(busy8), .done(done8), .result(res8)
  );

  sar_adc_ctrl #(.WIDTH(4), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(3)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .cmp(cmp4), .dac_code(dac4),
    .track(track4), .busy(busy4), .done(done4), .result(res4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Ideal binary search: each trial sets the next bit, keeps it if vin >= trial.
  function automatic int ref_sar(input int w, input int v);
    int code;
    int t;
    code = 0;
    exp_q.delete();
    for (int i = w - 1; i >= 0; i--) begin
      t = code | (1 << i);
      exp_q.push_back(t);
      if (v >= t) code = t;
    end
    return code;
  endfunction

  // Called just after a negedge with the selected DUT in IDLE.
  task automatic run_conv(input int v, input int pa, input int pb, input bit hold,
                          input string tag);
    int lat, exp_res, dones, last;
    lat = sel4 ? int'(LAT4) : int'(LAT8);
    if (sel4) vin4 = 4'(v); else vin8 = 8'(v);
    exp_res = ref_sar(sel4 ? 4 : 8, v);
    start_drv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_drv = hold;
    check_eq({tag, "_busy_on"}, 32'(mon_busy), 32'd1);
    check_eq({tag, "_track_on"}, 32'(mon_track), 32'd1);
    check_eq({tag, "_dac_sample"}, 32'(mon_dac), 32'd0);
    got_q.delete();
    last  = -1;
    dones = 0;
    for (int c = 1; c <= lat + 40; c++) begin
      @(negedge clk);
      start_drv = hold || (c == pa) || (c == pb);
      if (mon_busy && !mon_track && int'(mon_dac) != last) begin
        got_q.push_back(int'(mon_dac));
        last = int'(mon_dac);
      end
      if (mon_done) begin
        dones++;
        if (dones == 1) begin
          check_eq({tag, "_latency"}, 32'(c), 32'(lat));
          check_eq({tag, "_result"}, 32'(mon_res), 32'(exp_res));
          check_eq({tag, "_busy_done"}, 32'(mon_busy), 32'd0);
          check_eq({tag, "_dac_done"}, 32'(mon_dac), 32'(exp_res));
          check_eq({tag, "_ntrials"}, 32'(got_q.size()), 32'(exp_q.size()));
          for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            check_eq({tag, "_trial"}, 32'(got_q[k]), 32'(exp_q[k]));
        end
        if (hold) break;
      end
      if (!hold && c == lat + 1)
        check_eq({tag, "_dac_idle"}, 32'(mon_dac), 32'(exp_res));
    end
    check_eq({tag, "_ndone"}, 32'(dones), 32'd1);
  endtask

  initial begin
    int d;
    rst       = 1'b1;
    start_drv = 1'b0;
    sel4      = 1'b0;
    vin8      = 8'h00;
    vin4      = 4'h0;
    cyc_cnt   = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_outs8", {8'h0, dac8, res8, 5'h0, track8, busy8, done8}, 32'd0);
    check_eq("rst_outs4", {16'h0, dac4, res4, 5'h0, track4, busy4, done4}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_conv(8'hA5, 0, 0, 1'b0, "a5");
    run_conv(8'h00, 0, 0, 1'b0, "zero");
    run_conv(8'hFF, 0, 0, 1'b0, "full");

    run_conv(8'h3C, 0, 0, 1'b1, "b2b_1");
    run_conv(8'h3C, 0, 0, 1'b1, "b2b_2");
    run_conv(8'h3C, 0, 0, 1'b0, "b2b_3");

    run_conv(8'h5A, 5, 20, 1'b0, "ignore");

    // Reset in the middle of a conversion.
    vin8      = 8'h77;
    start_drv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_drv = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_outs", {8'h0, dac8, res8, 5'h0, track8, busy8, done8}, 32'd0);
    rst = 1'b0;
    d = 0;
    repeat (40) begin
      @(negedge clk);
      if (done8) d++;
    end
    check_eq("midrst_nodone", 32'(d), 32'd0);
    run_conv(8'h77, 0, 0, 1'b0, "after_rst");

    for (int r = 0; r < 12; r++)
      run_conv(int'($urandom_range(255)), 0, 0, 1'b0, "rand8");

    sel4 = 1'b1;
    @(negedge clk);
    run_conv(4'h9, 0, 0, 1'b0, "w4_9");
    for (int r = 0; r < 6; r++)
      run_conv(int'($urandom_range(15)), 0, 0, 1'b0, "rand4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop so the run can never hang.
  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + CYC_W'(1);
    if (cyc_cnt == '1 && $time > 20000000) begin
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
    end
  end

  initial begin
    #30000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
